dds_phase_gen: RTL and testbench

DDS_PHASE_GEN -- requirements
Module: dds_phase_gen

---
 rtl/dds_pkg.sv | 16 +
 rtl/dds_phase_acc.sv | 43 ++++
 rtl/dds_phase_gen.sv | 110 +++++++++++
 tb/tb_dds_phase_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// DDS phase generator shared definitions.
// Default widths and control state encoding.
package dds_pkg;

  localparam int DDS_DATA_W  = 8;
  localparam int DDS_ADDR_W  = 8;
  localparam int DDS_PHASE_W = 32;
  localparam int DDS_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } dds_state_t;

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with step register and
// start-time phase offset; phase = acc + offset.
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = DDS_PHASE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   step,
  input  logic [PHASE_WIDTH-1:0] fcw,
  input  logic                   fcw_load,
  input  logic [PHASE_WIDTH-1:0] pow,
  output logic [PHASE_WIDTH-1:0] phase
);

  logic [PHASE_WIDTH-1:0] acc;
  logic [PHASE_WIDTH-1:0] pow_reg;
  logic [PHASE_WIDTH-1:0] fcw_reg;

  // A load takes effect on the following step,
  // the current step still uses the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      pow_reg <= '0;
      fcw_reg <= '0;
    end else begin
      if (fcw_load)
        fcw_reg <= fcw;
      if (clear) begin
        acc     <= '0;
        pow_reg <= pow;
      end else if (step) begin
        acc <= acc + fcw_reg;
      end
    end
  end

  assign phase = acc + pow_reg;

endmodule

// File: rtl/dds_phase_gen.sv
// DDS burst/continuous phase generator: control
// FSM, ROM address issue and 2-deep valid pipe.
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int DATA_WIDTH  = DDS_DATA_W,
  parameter int ADDR_WIDTH  = DDS_ADDR_W,
  parameter int PHASE_WIDTH = DDS_PHASE_W,
  parameter int CNT_WIDTH   = DDS_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [CNT_WIDTH-1:0]   burst_len,
  input  logic [PHASE_WIDTH-1:0] fcw,
  input  logic                   fcw_load,
  input  logic [PHASE_WIDTH-1:0] pow,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_q,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic                   busy,
  output logic                   done
);

  dds_state_t             state;
  logic                   cont;
  logic [CNT_WIDTH-1:0]   remaining;
  logic                   v_addr;
  logic                   v_rom;
  logic [PHASE_WIDTH-1:0] phase;
  logic                   accept;
  logic                   last_issue;
  logic                   issue;

  assign accept     = (state == ST_IDLE) && start;
  assign last_issue = !cont &&
                      (remaining == CNT_WIDTH'(1));
  // A stop landing on the final burst address
  // still lets that address go out.
  assign issue = (state == ST_RUN) &&
                 (!stop || last_issue);

  dds_phase_acc #(
    .PHASE_WIDTH(PHASE_WIDTH)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .step     (issue),
    .fcw      (fcw),
    .fcw_load (fcw_load),
    .pow      (pow),
    .phase    (phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cont       <= 1'b0;
      remaining  <= '0;
      v_addr     <= 1'b0;
      v_rom      <= 1'b0;
      rom_addr   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      v_addr     <= issue;
      v_rom      <= v_addr;
      dout_valid <= v_rom;
      if (issue)
        rom_addr <= phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
      if (v_rom)
        dout <= rom_q;
      // Last sample: nothing behind it, no more issue.
      done <= v_rom && !v_addr &&
              (state == ST_DRAIN);
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            cont      <= (burst_len == '0);
            remaining <= burst_len;
            busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (issue && !cont)
            remaining <= remaining - CNT_WIDTH'(1);
          if (!issue || last_issue)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!v_addr && !v_rom) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Self-checking bench for dds_phase_gen with an
// identity waveform ROM and a sample-queue model.
module tb_dds_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        fcw_load = 1'b0;
  logic [15:0] burst_len = '0;
  logic [31:0] fcw = '0;
  logic [31:0] pow = '0;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_q;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // ROM[i] = i, one-cycle registered read
  always_ff @(posedge clk) rom_q <= rom_addr;

  dds_phase_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .burst_len  (burst_len),
    .fcw        (fcw),
    .fcw_load   (fcw_load),
    .pow        (pow),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int       due;
    bit [7:0] val;
    bit       last;
  } exp_t;

  exp_t      q[$];
  bit [7:0]  got[$];
  int        cyc = 0;
  bit        m_busy, m_gen, m_cont;
  bit        m_done_prev, m_valid, m_done;
  bit [31:0] m_acc, m_pow, m_step;
  int        m_left, m_issued;
  bit [7:0]  m_addr, m_dout;

  task automatic model_clear();
    q.delete();
    m_busy = 0; m_gen = 0; m_cont = 0;
    m_done_prev = 0; m_valid = 0; m_done = 0;
    m_acc = 0; m_pow = 0; m_step = 0;
    m_left = 0; m_issued = 0;
    m_addr = 0; m_dout = 0;
  endtask

  task automatic model_edge();
    bit        old_busy;
    bit        fin;
    bit [31:0] ph;
    exp_t      e;
    old_busy = m_busy;
    cyc++;
    if (m_done_prev) m_busy = 0;
    if (!old_busy && start) begin
      m_busy = 1; m_gen = 1;
      m_acc = 0; m_pow = pow;
      m_left = int'(burst_len);
      m_cont = (burst_len == 0);
      m_issued = 0;
    end else if (m_gen) begin
      fin = !m_cont && (m_left == 1);
      if (stop && !fin) begin
        m_gen = 0;
        if (q.size() > 0) begin
          e = q[q.size()-1];
          e.last = 1;
          q[q.size()-1] = e;
        end
      end else begin
        ph = m_acc + m_pow;
        m_addr = ph[31:24];
        e.due = cyc + 2;
        e.val = m_addr;
        e.last = fin;
        q.push_back(e);
        m_issued++;
        m_acc = m_acc + m_step;
        if (!m_cont) m_left--;
        if (fin) m_gen = 0;
      end
    end
    if (fcw_load) m_step = fcw;
    m_valid = 0;
    m_done = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      m_valid = 1;
      m_dout = e.val;
      m_done = e.last;
    end
    m_done_prev = m_done;
  endtask

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("rom_addr", rom_addr, m_addr);
    chk("dout", dout, m_dout);
    chk("dout_valid", dout_valid, m_valid);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    if (dout_valid === 1'b1) got.push_back(dout);
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_out();
    int n = 0;
    while ((m_busy || busy === 1'b1) && n < 300) begin
      step();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic check_seq(string tag,
                           input bit [7:0] e[$]);
    chk({tag, "_len"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++)
      chk(tag, got[i], e[i]);
  endtask

  task automatic load_fcw(bit [31:0] w);
    fcw = w;
    fcw_load = 1'b1;
    step();
    fcw_load = 1'b0;
  endtask

  task automatic go(bit [31:0] p, bit [15:0] n);
    pow = p;
    burst_len = n;
    got.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    bit [7:0] e[$];
    int       target;
    model_clear();
    apply_reset();

    // basic 4-sample burst
    load_fcw(32'h0100_0000);
    go(32'h0, 16'd4);
    run_out();
    e = '{8'h00, 8'h01, 8'h02, 8'h03};
    check_seq("burst4", e);

    // half-cycle step with quarter offset
    load_fcw(32'h8000_0000);
    go(32'h4000_0000, 16'd3);
    run_out();
    e = '{8'h40, 8'hC0, 8'h40};
    check_seq("half_step", e);

    // continuous, 300 samples, wrap at 0xFF
    load_fcw(32'h0100_0000);
    go(32'h0, 16'd0);
    for (int n = 0; n < 400 && m_issued < 300; n++)
      step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    run_out();
    e.delete();
    for (int i = 0; i < 300; i++) e.push_back(8'(i));
    check_seq("cont300", e);

    // step change after the third address
    go(32'h0, 16'd6);
    for (int n = 0; n < 10 && m_issued < 2; n++)
      step();
    load_fcw(32'h0200_0000);
    run_out();
    e = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h07};
    check_seq("fcw_change", e);

    // reset in the middle of a continuous run
    load_fcw(32'h0100_0000);
    go(32'h0, 16'd0);
    repeat (5) step();
    apply_reset();
    repeat (4) step();
    load_fcw(32'h0100_0000);
    go(32'h0500_0000, 16'd2);
    run_out();
    e = '{8'h05, 8'h06};
    check_seq("after_reset", e);

    // start while busy, stop while idle/draining
    stop = 1'b1;
    step();
    stop = 1'b0;
    go(32'h0, 16'd5);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 20 && m_gen; n++) step();
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    run_out();
    e = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    check_seq("ignored_ctl", e);

    // randomized runs against the model
    for (int r = 0; r < 16; r++) begin
      load_fcw($urandom);
      go($urandom, (r % 4 == 0) ? 16'd0 :
          16'($urandom_range(1, 20)));
      target = $urandom_range(5, 40);
      for (int c = 0; c < 80 && m_gen; c++) begin
        stop = (m_cont && m_issued >= target) ||
               (!m_cont && m_issued >= 1 &&
                $urandom_range(0, 29) == 0);
        start = ($urandom_range(0, 7) == 0);
        fcw_load = ($urandom_range(0, 7) == 0);
        fcw = $urandom;
        step();
      end
      stop = 1'b0;
      start = 1'b0;
      fcw_load = 1'b0;
      run_out();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
